// File: rtl/ssm_demux_fifo.sv
// Substream demultiplexer: steers 128-bit mux words into per-substream prefetch FIFOs,
// first by a round-robin preload, then in the order the bit parsers consumed words.
module ssm_demux_fifo #(
   parameter int NUM_SSM    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int INIT_WORDS = 2,
   parameter int WORD_W     = 128
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [WORD_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [NUM_SSM*WORD_W-1:0] codec_data,
   input  logic [NUM_SSM-1:0]        codec_data_rd_en,
   output logic [NUM_SSM-1:0]        ssm_empty,
   output logic [NUM_SSM*4-1:0]      ssm_level,
   output logic                      underflow_err,
   output logic                      reqq_overflow_err
);
   localparam int IDX_W      = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;
   localparam int FP_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int RQ_DEPTH   = NUM_SSM * FIFO_DEPTH;
   localparam int RQP_W      = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
   localparam int RQC_W      = $clog2(RQ_DEPTH + 1);
   localparam int RQS_W      = RQC_W + 1;
   localparam int INIT_TOTAL = NUM_SSM * INIT_WORDS;
   localparam int IC_W       = $clog2(INIT_TOTAL + 1);

   typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

   state_t             state, state_nxt;
   logic [WORD_W-1:0]  mem [NUM_SSM][FIFO_DEPTH];
   logic [FP_W-1:0]    rd_ptr [NUM_SSM];
   logic [FP_W-1:0]    wr_ptr [NUM_SSM];
   logic [3:0]         level [NUM_SSM];
   logic [IDX_W-1:0]   rq_mem [RQ_DEPTH];
   logic [RQP_W-1:0]   rq_rd, rq_wr;
   logic [RQC_W-1:0]   rq_cnt;
   logic [IC_W-1:0]    init_cnt;
   logic [IDX_W-1:0]   target;
   logic               accept, active, rq_pop, rq_ovf;
   logic [NUM_SSM-1:0] full, push_en, pop_ok, pop_bad, rq_push_ok;
   logic [RQS_W-1:0]   rq_off [NUM_SSM];
   logic [RQS_W-1:0]   rq_npush;

   // FIFO status and head words, all straight from registered storage
   always_comb begin
      ssm_empty  = '0;
      full       = '0;
      ssm_level  = '0;
      codec_data = '0;
      for (int k = 0; k < NUM_SSM; k++) begin
         ssm_empty[k]           = (level[k] == 4'd0);
         full[k]                = (level[k] == 4'(FIFO_DEPTH));
         ssm_level[k*4 +: 4]    = level[k];
         codec_data[k*WORD_W +: WORD_W] = (level[k] == 4'd0) ? '0 : mem[k][rd_ptr[k]];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      target    = '0;
      case (state)
         IDLE: ;
         INIT: begin
            target   = IDX_W'(32'(init_cnt) % NUM_SSM);
            in_ready = ~full[target];
            if (in_valid && in_ready && init_cnt == IC_W'(INIT_TOTAL - 1))
               state_nxt = RUN;
         end
         RUN: begin
            target   = rq_mem[rq_rd];
            in_ready = (rq_cnt != '0) && ~full[target];
         end
         default: state_nxt = IDLE;
      endcase
      if (start) state_nxt = INIT;
   end

   // start wins over any same-cycle accept or pop
   assign accept  = in_valid & in_ready & ~start;
   assign active  = (state != IDLE) & ~start;
   assign rq_pop  = accept & (state == RUN);
   assign pop_ok  = codec_data_rd_en & ~ssm_empty & {NUM_SSM{active}};
   assign pop_bad = codec_data_rd_en & ssm_empty & {NUM_SSM{active}};

   always_comb begin
      push_en = '0;
      for (int k = 0; k < NUM_SSM; k++)
         push_en[k] = accept && (target == IDX_W'(k));
   end

   // Consumed-word requests enqueue in ascending substream order; slots freed by
   // this cycle's dequeue are available to this cycle's enqueues.
   always_comb begin
      rq_push_ok = '0;
      rq_ovf     = 1'b0;
      rq_npush   = '0;
      for (int k = 0; k < NUM_SSM; k++) begin
         rq_off[k] = rq_npush;
         if (pop_ok[k]) begin
            if ((RQS_W'(rq_cnt) - RQS_W'(rq_pop) + rq_npush) >= RQS_W'(RQ_DEPTH)) begin
               rq_ovf = 1'b1;
            end else begin
               rq_push_ok[k] = 1'b1;
               rq_npush      = rq_npush + RQS_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_SSM; k++) begin
            rd_ptr[k] <= '0;
            wr_ptr[k] <= '0;
            level[k]  <= '0;
         end
         rq_rd             <= '0;
         rq_wr             <= '0;
         rq_cnt            <= '0;
         init_cnt          <= '0;
         underflow_err     <= 1'b0;
         reqq_overflow_err <= 1'b0;
      end else if (start) begin
         for (int k = 0; k < NUM_SSM; k++) begin
            rd_ptr[k] <= '0;
            wr_ptr[k] <= '0;
            level[k]  <= '0;
         end
         rq_rd             <= '0;
         rq_wr             <= '0;
         rq_cnt            <= '0;
         init_cnt          <= '0;
         underflow_err     <= 1'b0;
         reqq_overflow_err <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_SSM; k++) begin
            if (push_en[k]) wr_ptr[k] <= wr_ptr[k] + FP_W'(1);
            if (pop_ok[k])  rd_ptr[k] <= rd_ptr[k] + FP_W'(1);
            level[k] <= level[k] + 4'(push_en[k]) - 4'(pop_ok[k]);
         end
         if (accept && state == INIT) init_cnt <= init_cnt + IC_W'(1);
         if (rq_pop) rq_rd <= rq_rd + RQP_W'(1);
         rq_wr  <= rq_wr + RQP_W'(rq_npush);
         rq_cnt <= RQC_W'(RQS_W'(rq_cnt) - RQS_W'(rq_pop) + rq_npush);
         if (|pop_bad) underflow_err     <= 1'b1;
         if (rq_ovf)   reqq_overflow_err <= 1'b1;
      end
   end

   // Payload storage carries no reset; occupancy counters define what is valid
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_SSM; k++) begin
         if (push_en[k]) mem[k][wr_ptr[k]] <= in_data;
         if (rq_push_ok[k]) rq_mem[rq_wr + RQP_W'(rq_off[k])] <= IDX_W'(k);
      end
   end

endmodule

// File: tb/tb_ssm_demux_fifo.sv
// Directed bench for ssm_demux_fifo: preload, request-ordered steering, same-cycle
// pops, push+pop on one FIFO, underflow, mid-run start and asynchronous reset.
module tb_ssm_demux_fifo;
   localparam int NUM_SSM    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int INIT_WORDS = 2;
   localparam int WORD_W     = 128;

   logic                      clk = 1'b0;
   logic                      rstn, start, in_valid, in_ready;
   logic                      underflow_err, reqq_overflow_err;
   logic [WORD_W-1:0]         in_data;
   logic [NUM_SSM*WORD_W-1:0] codec_data;
   logic [NUM_SSM-1:0]        codec_data_rd_en, ssm_empty;
   logic [NUM_SSM*4-1:0]      ssm_level;
   int vecs = 0;
   int errs = 0;

   ssm_demux_fifo #(
      .NUM_SSM(NUM_SSM), .FIFO_DEPTH(FIFO_DEPTH), .INIT_WORDS(INIT_WORDS), .WORD_W(WORD_W)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .codec_data(codec_data), .codec_data_rd_en(codec_data_rd_en),
      .ssm_empty(ssm_empty), .ssm_level(ssm_level), .underflow_err(underflow_err),
      .reqq_overflow_err(reqq_overflow_err)
   );

   always #5 clk = ~clk;

   function automatic logic [WORD_W-1:0] w(input int i);
      return {4{32'hC0DE_0000 + 32'(i)}};
   endfunction

   function automatic logic [WORD_W-1:0] slice(input int k);
      return codec_data[k*WORD_W +: WORD_W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WORD_W-1:0] d);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      vecs++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL send_timeout in_ready=%0b required=1 word=%0h", in_ready, d);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop(input logic [NUM_SSM-1:0] m);
      codec_data_rd_en = m;
      tick();
      codec_data_rd_en = '0;
   endtask

   task automatic test_reset();
      rstn = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; codec_data_rd_en = '0;
      #1 rstn = 1'b0;
      #2;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%0b req=0", in_ready); end
      vecs++; if (ssm_empty !== 4'hF) begin errs++; $display("FAIL rst_empty got=%0h req=f", ssm_empty); end
      vecs++; if (ssm_level !== 16'h0000) begin errs++; $display("FAIL rst_level got=%0h req=0", ssm_level); end
      vecs++; if (codec_data !== '0) begin errs++; $display("FAIL rst_codec_data got=%0h req=0", codec_data); end
      vecs++; if ({underflow_err, reqq_overflow_err} !== 2'b00) begin
         errs++; $display("FAIL rst_errors got=%0b req=00", {underflow_err, reqq_overflow_err});
      end
      tick(); tick();
      rstn = 1'b1;
      in_valid = 1'b1; in_data = w(90);
      tick();
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL idle_in_ready got=%0b req=0", in_ready); end
      in_valid = 1'b0;
   endtask

   task automatic test_preload();
      start = 1'b1; tick(); start = 1'b0;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL init_in_ready got=%0b req=1", in_ready); end
      for (int i = 0; i < 8; i++) send(w(i));
      vecs++; if (ssm_level !== 16'h2222) begin errs++; $display("FAIL pre_level got=%0h req=2222", ssm_level); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL pre_in_ready got=%0b req=0", in_ready); end
      for (int k = 0; k < NUM_SSM; k++) begin
         vecs++;
         if (slice(k) !== w(k)) begin errs++; $display("FAIL pre_head%0d got=%0h req=%0h", k, slice(k), w(k)); end
      end
      in_valid = 1'b1; in_data = w(99);
      tick();
      in_valid = 1'b0;
      vecs++; if (ssm_level !== 16'h2222) begin errs++; $display("FAIL run_noreq_level got=%0h req=2222", ssm_level); end
   endtask

   task automatic test_request_order();
      pop(4'b0100);
      vecs++; if (slice(2) !== w(6)) begin errs++; $display("FAIL ro_head2 got=%0h req=%0h", slice(2), w(6)); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ro_in_ready got=%0b req=1", in_ready); end
      tick(); tick();
      pop(4'b0001);
      vecs++; if (ssm_level !== 16'h2121) begin errs++; $display("FAIL ro_level got=%0h req=2121", ssm_level); end
      vecs++; if (slice(0) !== w(4)) begin errs++; $display("FAIL ro_head0 got=%0h req=%0h", slice(0), w(4)); end
      send(w(8));
      send(w(9));
      vecs++; if (ssm_level !== 16'h2222) begin errs++; $display("FAIL ro_level2 got=%0h req=2222", ssm_level); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ro_drained got=%0b req=0", in_ready); end
      pop(4'b0100);
      vecs++; if (slice(2) !== w(8)) begin errs++; $display("FAIL ro_w8 got=%0h req=%0h", slice(2), w(8)); end
      pop(4'b0001);
      vecs++; if (slice(0) !== w(9)) begin errs++; $display("FAIL ro_w9 got=%0h req=%0h", slice(0), w(9)); end
      send(w(20));
      send(w(21));
      vecs++; if (ssm_level !== 16'h2222) begin errs++; $display("FAIL ro_level3 got=%0h req=2222", ssm_level); end
   endtask

   task automatic test_simultaneous();
      pop(4'b1010);
      vecs++; if (ssm_level !== 16'h1212) begin errs++; $display("FAIL sim_level got=%0h req=1212", ssm_level); end
      send(w(10));
      send(w(11));
      pop(4'b1010);
      vecs++; if (slice(1) !== w(10)) begin errs++; $display("FAIL sim_w10 got=%0h req=%0h", slice(1), w(10)); end
      vecs++; if (slice(3) !== w(11)) begin errs++; $display("FAIL sim_w11 got=%0h req=%0h", slice(3), w(11)); end
      send(w(22));
      send(w(23));
      vecs++; if (ssm_level !== 16'h2222) begin errs++; $display("FAIL sim_level2 got=%0h req=2222", ssm_level); end
   endtask

   task automatic test_push_pop_same();
      pop(4'b0001);
      vecs++; if (ssm_level !== 16'h2221) begin errs++; $display("FAIL pp_level got=%0h req=2221", ssm_level); end
      codec_data_rd_en = 4'b0001; in_valid = 1'b1; in_data = w(12);
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL pp_in_ready got=%0b req=1", in_ready); end
      tick();
      codec_data_rd_en = '0; in_valid = 1'b0;
      vecs++; if (ssm_level !== 16'h2221) begin errs++; $display("FAIL pp_level2 got=%0h req=2221", ssm_level); end
      vecs++; if (slice(0) !== w(12)) begin errs++; $display("FAIL pp_head got=%0h req=%0h", slice(0), w(12)); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL pp_requeued got=%0b req=1", in_ready); end
      send(w(24));
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL pp_drained got=%0b req=0", in_ready); end
   endtask

   task automatic test_underflow();
      pop(4'b0010);
      vecs++; if (slice(1) !== w(22)) begin errs++; $display("FAIL uf_w22 got=%0h req=%0h", slice(1), w(22)); end
      pop(4'b0010);
      vecs++; if (underflow_err !== 1'b0) begin errs++; $display("FAIL uf_pre got=%0b req=0", underflow_err); end
      pop(4'b0010);
      vecs++; if (underflow_err !== 1'b1) begin errs++; $display("FAIL uf_flag got=%0b req=1", underflow_err); end
      vecs++; if (ssm_level !== 16'h2202) begin errs++; $display("FAIL uf_level got=%0h req=2202", ssm_level); end
      vecs++; if (ssm_empty !== 4'b0010) begin errs++; $display("FAIL uf_empty got=%0b req=0010", ssm_empty); end
      vecs++; if (slice(1) !== '0) begin errs++; $display("FAIL uf_slice got=%0h req=0", slice(1)); end
      send(w(25));
      send(w(26));
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL uf_reqq got=%0b req=0", in_ready); end
      vecs++; if (slice(1) !== w(25)) begin errs++; $display("FAIL uf_w25 got=%0h req=%0h", slice(1), w(25)); end
      vecs++; if ({underflow_err, reqq_overflow_err} !== 2'b10) begin
         errs++; $display("FAIL uf_sticky got=%0b req=10", {underflow_err, reqq_overflow_err});
      end
   endtask

   task automatic test_start();
      pop(4'b0100);
      start = 1'b1; in_valid = 1'b1; in_data = w(30); codec_data_rd_en = 4'b0001;
      tick();
      start = 1'b0; in_valid = 1'b0; codec_data_rd_en = '0;
      vecs++; if (ssm_empty !== 4'hF) begin errs++; $display("FAIL st_empty got=%0h req=f", ssm_empty); end
      vecs++; if (ssm_level !== 16'h0000) begin errs++; $display("FAIL st_level got=%0h req=0", ssm_level); end
      vecs++; if (underflow_err !== 1'b0) begin errs++; $display("FAIL st_err got=%0b req=0", underflow_err); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL st_in_ready got=%0b req=1", in_ready); end
      for (int i = 0; i < 8; i++) send(w(40 + i));
      vecs++; if (ssm_level !== 16'h2222) begin errs++; $display("FAIL st_level2 got=%0h req=2222", ssm_level); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL st_run got=%0b req=0", in_ready); end
      for (int k = 0; k < NUM_SSM; k++) begin
         vecs++;
         if (slice(k) !== w(40 + k)) begin errs++; $display("FAIL st_head%0d got=%0h req=%0h", k, slice(k), w(40 + k)); end
      end
   endtask

   task automatic test_async_reset();
      pop(4'b0001);
      in_valid = 1'b1; in_data = w(50);
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ar_pre got=%0b req=1", in_ready); end
      #2 rstn = 1'b0;
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ar_in_ready got=%0b req=0", in_ready); end
      vecs++; if (ssm_empty !== 4'hF) begin errs++; $display("FAIL ar_empty got=%0h req=f", ssm_empty); end
      vecs++; if (ssm_level !== 16'h0000) begin errs++; $display("FAIL ar_level got=%0h req=0", ssm_level); end
      in_valid = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_preload();
      test_request_order();
      test_simultaneous();
      test_push_pop_same();
      test_underflow();
      test_start();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ssm_demux_fifo.md
Name: ssm_demux_fifo

Overview:
Substream demultiplexer directly upstream of the per-substream bit parsers. Accepts the muxed compressed bitstream as 128-bit mux words and steers each word into one of NUM_SSM prefetch FIFOs. The FIFO head drives each parser's codec_data, and a parser's codec_data_rd_en pops that head.
- Steering order: a fixed round-robin preload, then the order in which the parsers consumed words. This matches the encoder's mux-word emission order.

Parameters:
NUM_SSM, 4, number of substreams / bit parsers served
FIFO_DEPTH, 4, mux words per substream FIFO (power of two, >= INIT_WORDS+1)
INIT_WORDS, 2, mux words preloaded per substream before request-ordered demux starts
WORD_W, 128, mux word width

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
start  in  1  one-cycle pulse: flush everything, begin new slice
in_data  in  WORD_W  incoming mux word
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid & in_ready
codec_data  out  NUM_SSM*WORD_W  FIFO head per substream; slice k = [k*WORD_W +: WORD_W]
codec_data_rd_en  in  NUM_SSM  per-substream pop, bit k from parser k
ssm_empty  out  NUM_SSM  FIFO k empty
ssm_level  out  NUM_SSM*4  occupancy per FIFO (0..FIFO_DEPTH)
underflow_err  out  1  sticky: pop of an empty FIFO
reqq_overflow_err  out  1  sticky: request queue push while full

Behaviour:
- Reset (rstn=0, async):
  - state=IDLE; all FIFOs and the request queue empty.
  - in_ready=0, codec_data=0, ssm_empty=all 1, ssm_level=0, both error flags=0.
- State machine IDLE -> INIT -> RUN:
  - IDLE: in_ready=0; requests ignored. start -> INIT.
  - INIT: preload round-robin. Target = init_cnt mod NUM_SSM, init_cnt counting 0..NUM_SSM*INIT_WORDS-1.
    - in_ready = target FIFO not full.
    - After the accept with init_cnt = NUM_SSM*INIT_WORDS-1 -> RUN next cycle.
  - RUN: target = index at the head of the request queue.
    - in_ready = reqq not empty AND target FIFO not full.
    - An accept pops reqq and pushes in_data into the target FIFO.
  - start in any state: synchronous flush of FIFOs, reqq, init_cnt and error flags; next state INIT. start has priority over a same-cycle accept or pop; those are discarded.
- Request queue:
  - Depth NUM_SSM*FIFO_DEPTH; entry width clog2(NUM_SSM).
  - Every accepted pop (rd_en[k] & ~empty[k]) in INIT or RUN enqueues k.
  - Multiple pops in one cycle enqueue in ascending k order, up to NUM_SSM pushes per cycle.
  - Push and pop in the same cycle are legal; the pop takes the pre-cycle head.
- FIFOs:
  - Registered storage. A word accepted at edge t is visible on codec_data/ssm_level after edge t, i.e. 1-cycle latency.
  - codec_data slice k = head word while non-empty, else 0; it is valid combinationally from storage.
  - rd_en[k] pops at the edge. Pop and push on the same FIFO in one cycle: level unchanged, head advances, new word goes to tail.
  - A pop on an empty FIFO: no state change, not enqueued, underflow_err <= 1.
  - Pointers wrap modulo FIFO_DEPTH; level is computed with a separate counter, so full and empty are unambiguous.
- Back-pressure:
  - in_ready never depends on in_valid.
  - Data must hold while in_valid & ~in_ready.
- Sticky errors clear only on rstn or start.

Test Plan:
- Preload: NUM_SSM=4, INIT_WORDS=2, start, stream words W0..W7 with in_valid=1 and no pops.
  - Required: FIFO0={W0,W4}, FIFO1={W1,W5}, FIFO2={W2,W6}, FIFO3={W3,W7}.
  - Required: ssm_level=2 each, state RUN, in_ready=0 (reqq empty).
- Request order: after preload, pop ssm2 at cycle c and ssm0 at c+3, then send W8, W9.
  - Required: W8 lands at FIFO2 tail, W9 at FIFO0 tail.
  - Required: codec_data slice2 = W6, then W8 after the next pop of ssm2.
- Simultaneous pops: pop ssm3 and ssm1 in one cycle, then send W10, W11.
  - Required: W10 goes to FIFO1, W11 goes to FIFO3 (ascending order).
- Push+pop same FIFO: FIFO0 level 1, pop ssm0 in the same cycle as W12 is accepted for ssm0.
  - Required: level stays 1, head = W12.
- Underflow: pop ssm1 with level 0.
  - Required: underflow_err=1, reqq unchanged, codec_data slice1 = 0.
- Mid-operation start and reset: start while in RUN with words pending.
  - Required: next cycle all ssm_empty=1, errors cleared, state INIT, init_cnt restarts at 0.
  - Required: rstn asserted mid-stream forces in_ready=0 with no clock edge.
